// File: rtl/branch_redirect_if.sv
// Bundle between branch execute, this redirect stage, fetch and the register-file write port.
// slave is the redirect stage's view; master is the surrounding pipeline's view.
interface branch_redirect_if #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic                  ex_is_nop;
  logic                  ex_taken;
  logic [PC_W-1:0]       ex_target;
  logic [PC_W-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_rd_wr_en;

  logic                  redir_valid;
  logic                  redir_ready;
  logic [PC_W-1:0]       redir_pc;
  logic                  squash;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [PC_W-1:0]       wb_data;

  logic                  misalign_err;
  logic [CNT_W-1:0]      taken_count;

  modport slave (
    input  ex_valid, ex_is_nop, ex_taken, ex_target, ex_pc, ex_rd, ex_rd_wr_en, redir_ready,
    output ex_ready, redir_valid, redir_pc, squash, wb_en, wb_addr, wb_data, misalign_err,
           taken_count
  );

  modport master (
    output ex_valid, ex_is_nop, ex_taken, ex_target, ex_pc, ex_rd, ex_rd_wr_en, redir_ready,
    input  ex_ready, redir_valid, redir_pc, squash, wb_en, wb_addr, wb_data, misalign_err,
           taken_count
  );
endinterface

// File: rtl/branch_redirect.sv
// Post-execute redirect stage: turns a resolved taken branch into a fetch redirect, squashes
// younger bundles for a fixed window, writes back jump link values and counts redirects.
module branch_redirect #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_redirect_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  state_e                state_q, state_d;
  logic                  redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]       redir_pc_q, redir_pc_d;
  logic                  squash_q, squash_d;
  logic                  wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [PC_W-1:0]       wb_data_q, wb_data_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_W-1:0]      taken_count_q, taken_count_d;
  logic [3:0]            flush_cnt_q, flush_cnt_d;

  logic ex_ready;
  logic accept;
  logic aligned;

  assign ex_ready = (state_q == StIdle);
  assign accept   = bus.ex_valid & ex_ready & ~bus.ex_is_nop;
  assign aligned  = (bus.ex_target[1:0] == 2'b00);

  always_comb begin
    state_d       = state_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    squash_d      = squash_q;
    wb_en_d       = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    misalign_d    = 1'b0;
    taken_count_d = taken_count_q;
    flush_cnt_d   = flush_cnt_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.ex_taken && aligned) begin
            redir_pc_d    = bus.ex_target;
            redir_valid_d = 1'b1;
            squash_d      = 1'b1;
            state_d       = StRedirect;
          end else if (bus.ex_taken) begin
            misalign_d = 1'b1;
          end
          // A misaligned taken jump must not leave a link value behind.
          if (bus.ex_rd_wr_en && (bus.ex_rd != '0) && (!bus.ex_taken || aligned)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = bus.ex_rd;
            wb_data_d = bus.ex_pc + PC_W'(4);
          end
        end
      end
      StRedirect: begin
        if (bus.redir_ready) begin
          redir_valid_d = 1'b0;
          if (taken_count_q != '1) begin
            taken_count_d = taken_count_q + CNT_W'(1);
          end
          if (FLUSH_CYCLES == 0) begin
            squash_d = 1'b0;
            state_d  = StIdle;
          end else begin
            flush_cnt_d = FlushInit;
            state_d     = StFlush;
          end
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q == 4'd1) begin
          squash_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        redir_valid_d = 1'b0;
        squash_d      = 1'b0;
        state_d       = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      squash_q      <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      misalign_q    <= 1'b0;
      taken_count_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      squash_q      <= squash_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      misalign_q    <= misalign_d;
      taken_count_q <= taken_count_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.ex_ready     = ex_ready;
  assign bus.redir_valid  = redir_valid_q;
  assign bus.redir_pc     = redir_pc_q;
  assign bus.squash       = squash_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_err = misalign_q;
  assign bus.taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: directed cases with literal expectations, then random traffic,
// with every output compared each cycle against a transaction-level model.
module tb_branch_redirect;

  localparam int unsigned PcW    = 32;
  localparam int unsigned RegW   = 5;
  localparam int unsigned Flush  = 2;
  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_redirect_if #(.PC_W(PcW), .REG_ADDR_W(RegW), .CNT_W(CntW)) bus ();

  branch_redirect #(
    .PC_W(PcW), .REG_ADDR_W(RegW), .FLUSH_CYCLES(Flush), .CNT_W(CntW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
  endtask

  // Model: a pending redirect waits for fetch, then a squash window of Flush cycles follows.
  bit          m_redir_valid = 1'b0;
  logic [31:0] m_redir_pc    = '0;
  int          m_sq_left     = 0;
  bit          m_squash      = 1'b0;
  bit          m_wb_en       = 1'b0;
  logic [4:0]  m_wb_addr     = '0;
  logic [31:0] m_wb_data     = '0;
  bit          m_mis         = 1'b0;
  int          m_cnt         = 0;

  initial forever begin
    bit busy;
    @(posedge clk);
    busy = m_redir_valid || (m_sq_left > 0);
    if (rst) begin
      m_redir_valid = 0; m_redir_pc = '0; m_sq_left = 0; m_squash = 0;
      m_wb_en = 0; m_wb_addr = '0; m_wb_data = '0; m_mis = 0; m_cnt = 0;
    end else begin
      m_wb_en = 0;
      m_mis   = 0;
      if (m_redir_valid) begin
        if (bus.redir_ready) begin
          if (m_cnt < CntMax) m_cnt++;
          m_redir_valid = 0;
          m_sq_left     = Flush;
          m_squash      = (Flush > 0);
        end
      end else if (busy) begin
        m_sq_left--;
        m_squash = (m_sq_left > 0);
      end else if (bus.ex_valid && !bus.ex_is_nop) begin
        bit ok;
        ok = (bus.ex_target % 4) == 0;
        if (bus.ex_taken && ok) begin
          m_redir_valid = 1; m_redir_pc = bus.ex_target; m_squash = 1;
        end
        if (bus.ex_taken && !ok) m_mis = 1;
        if (bus.ex_rd_wr_en && bus.ex_rd != 0 && (!bus.ex_taken || ok)) begin
          m_wb_en = 1; m_wb_addr = bus.ex_rd; m_wb_data = bus.ex_pc + 32'd4;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_ex_ready",     32'(bus.ex_ready),     32'(!(m_redir_valid || m_sq_left > 0)));
      chk("m_redir_valid",  32'(bus.redir_valid),  32'(m_redir_valid));
      chk("m_redir_pc",     bus.redir_pc,          m_redir_pc);
      chk("m_squash",       32'(bus.squash),       32'(m_squash));
      chk("m_wb_en",        32'(bus.wb_en),        32'(m_wb_en));
      chk("m_wb_addr",      32'(bus.wb_addr),      32'(m_wb_addr));
      chk("m_wb_data",      bus.wb_data,           m_wb_data);
      chk("m_misalign_err", 32'(bus.misalign_err), 32'(m_mis));
      chk("m_taken_count",  32'(bus.taken_count),  32'(m_cnt));
    end
  end

  task automatic drive(input bit v, input bit nop, input bit tk, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic [4:0] rd, input bit wr);
    bus.ex_valid = v; bus.ex_is_nop = nop; bus.ex_taken = tk; bus.ex_target = tgt;
    bus.ex_pc = pc; bus.ex_rd = rd; bus.ex_rd_wr_en = wr;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, '0, '0, '0, 0);
    bus.redir_ready = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
    chk("rst_taken_count", 32'(bus.taken_count), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    rst = 1'b0;
    step();

    // Taken branch, fetch ready at once.
    bus.redir_ready = 1'b1;
    drive(1, 0, 1, 32'h140, 32'h100, 5'd0, 0);
    step();
    drive(0, 0, 0, '0, '0, '0, 0);
    chk("beq_redir_valid", 32'(bus.redir_valid), 32'd1);
    chk("beq_redir_pc", bus.redir_pc, 32'h140);
    chk("beq_squash_n1", 32'(bus.squash), 32'd1);
    chk("beq_ready_n1", 32'(bus.ex_ready), 32'd0);
    step();
    chk("beq_squash_n2", 32'(bus.squash), 32'd1);
    chk("beq_valid_n2", 32'(bus.redir_valid), 32'd0);
    chk("beq_count", 32'(bus.taken_count), 32'd1);
    step();
    chk("beq_squash_n3", 32'(bus.squash), 32'd1);
    chk("beq_ready_n3", 32'(bus.ex_ready), 32'd0);
    step();
    chk("beq_squash_n4", 32'(bus.squash), 32'd0);
    chk("beq_ready_n4", 32'(bus.ex_ready), 32'd1);

    // JAL with fetch stalled five cycles; a new result offered meanwhile must be ignored.
    bus.redir_ready = 1'b0;
    drive(1, 0, 1, 32'h400, 32'h200, 5'd1, 1);
    step();
    chk("jal_wb_en", 32'(bus.wb_en), 32'd1);
    chk("jal_wb_addr", 32'(bus.wb_addr), 32'd1);
    chk("jal_wb_data", bus.wb_data, 32'h204);
    drive(1, 0, 1, 32'h800, 32'h220, 5'd2, 1);
    for (int i = 0; i < 5; i++) begin
      chk("jal_stall_valid", 32'(bus.redir_valid), 32'd1);
      chk("jal_stall_pc", bus.redir_pc, 32'h400);
      chk("jal_stall_squash", 32'(bus.squash), 32'd1);
      step();
    end
    chk("jal_no_wb", 32'(bus.wb_en), 32'd0);
    drive(0, 0, 0, '0, '0, '0, 0);
    bus.redir_ready = 1'b1;
    step();
    chk("jal_count", 32'(bus.taken_count), 32'd2);
    step();
    step();
    chk("jal_idle_ready", 32'(bus.ex_ready), 32'd1);

    // Misaligned taken target.
    drive(1, 0, 1, 32'h102, 32'h300, 5'd3, 1);
    step();
    drive(0, 0, 0, '0, '0, '0, 0);
    chk("mis_err", 32'(bus.misalign_err), 32'd1);
    chk("mis_no_valid", 32'(bus.redir_valid), 32'd0);
    chk("mis_no_wb", 32'(bus.wb_en), 32'd0);
    chk("mis_ready", 32'(bus.ex_ready), 32'd1);
    step();
    chk("mis_pulse_end", 32'(bus.misalign_err), 32'd0);

    // Link value wraps at the top of the address space; rd=0 writes nothing.
    drive(1, 0, 1, 32'h1000, 32'hFFFF_FFFC, 5'd5, 1);
    step();
    drive(0, 0, 0, '0, '0, '0, 0);
    chk("wrap_wb_en", 32'(bus.wb_en), 32'd1);
    chk("wrap_wb_addr", 32'(bus.wb_addr), 32'd5);
    chk("wrap_wb_data", bus.wb_data, 32'h0);
    step(); step(); step();
    drive(1, 0, 0, 32'h0, 32'h500, 5'd0, 1);
    step();
    drive(0, 0, 0, '0, '0, '0, 0);
    chk("rd0_no_wb", 32'(bus.wb_en), 32'd0);
    chk("rd0_hold_data", bus.wb_data, 32'h0);

    // Reset while a redirect waits, with fetch accepting in the same cycle.
    bus.redir_ready = 1'b0;
    drive(1, 0, 1, 32'h600, 32'h580, 5'd0, 0);
    step();
    drive(0, 0, 0, '0, '0, '0, 0);
    chk("rst_mid_valid_pre", 32'(bus.redir_valid), 32'd1);
    rst = 1'b1;
    bus.redir_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(bus.redir_valid), 32'd0);
    chk("rst_mid_squash", 32'(bus.squash), 32'd0);
    chk("rst_mid_count", 32'(bus.taken_count), 32'd0);
    chk("rst_mid_ready", 32'(bus.ex_ready), 32'd1);

    // NOP slot is ignored.
    drive(1, 1, 1, 32'h700, 32'h6f0, 5'd7, 1);
    step();
    drive(0, 0, 0, '0, '0, '0, 0);
    chk("nop_no_valid", 32'(bus.redir_valid), 32'd0);
    chk("nop_no_wb", 32'(bus.wb_en), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt, pc, r;
      r   = $urandom;
      tgt = $urandom;
      if ($urandom_range(0, 4) != 0) tgt = {tgt[31:2], 2'b00};
      pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), r[0], tgt, pc,
            ($urandom_range(0, 5) == 0) ? 5'd0 : r[8:4], r[1]);
      bus.redir_ready = r[2];
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, '0, 0);

    // Counter saturation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.redir_ready = 1'b1;
    for (int i = 0; i < CntMax + 3; i++) begin
      drive(1, 0, 1, 32'h2000 + 32'(i * 4), 32'h1000, 5'd0, 0);
      step();
      drive(0, 0, 0, '0, '0, '0, 0);
      step(); step(); step();
    end
    chk("sat_count", 32'(bus.taken_count), 32'(CntMax));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
